// File: rtl/fifo_pkg.sv
// Shared definitions for the flexible synchronous FIFO: read-mode constants
// and the width helper used to size pointers and the occupancy counter.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Bits needed to index 'value' distinct states, never less than one.
    function automatic int fifo_clog2(input int value);
        int bits;
        if (value <= 2) begin
            bits = 1;
        end else begin
            bits = $clog2(value);
        end
        return bits;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer handshake bundle of the flexible synchronous FIFO.
// The FIFO itself attaches through the slave modport.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 5
);
    logic                  push;
    logic [DATA_WIDTH-1:0] din;
    logic                  pop;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, din, pop,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, din, pop,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port. A read of the address being written returns the old contents.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost flags, overflow/underflow
// pulses and a choice of registered or first-word-fall-through read.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic            clk,
    input  logic            rstn,
    sync_fifo_flex_if.slave bus
);
    localparam int PTR_W = fifo_clog2(DEPTH);
    localparam int CNT_W = fifo_clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    assign w_pop_ok  = bus.pop & ~r_empty;
    assign w_push_ok = bus.push & (~r_full | w_pop_ok);

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push_ok & rstn),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Occupancy after this cycle's accepted operations.
    always_comb begin
        w_cnt_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_cnt_next = r_count + CNT_W'(1);
            2'b01:   w_cnt_next = r_count - CNT_W'(1);
            default: w_cnt_next = r_count;
        endcase
    end

    // Pointers, count, status flags and error pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count  <= w_cnt_next;
            r_full   <= (w_cnt_next == CNT_FULL);
            r_empty  <= (w_cnt_next == {CNT_W{1'b0}});
            r_afull  <= (w_cnt_next >= CNT_AF);
            r_aempty <= (w_cnt_next <= CNT_AE);
            r_ovf    <= bus.push & ~w_push_ok;
            r_udf    <= bus.pop & ~w_pop_ok;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign bus.dout       = w_rd_data;
            assign bus.dout_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_dout_valid;

            // Registered read: head captured on the popping edge, valid for one cycle.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_dout       <= {DATA_WIDTH{1'b0}};
                    r_dout_valid <= 1'b0;
                end else begin
                    if (w_pop_ok) begin
                        r_dout <= w_rd_data;
                    end else begin
                        r_dout <= r_dout;
                    end
                    r_dout_valid <= w_pop_ok;
                end
            end

            assign bus.dout       = r_dout;
            assign bus.dout_valid = r_dout_valid;
        end
    endgenerate

    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: three configurations (depth 16, depth 5,
// depth 16 FWFT) with a read-data scoreboard and direct flag checks.
module tb_sync_fifo_flex;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .CNT_W(5)) b16();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .CNT_W(3)) b5();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .CNT_W(5)) bf();

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(FWFT_OFF))
        u16 (.clk(clk), .rstn(rstn), .bus(b16));
    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(FWFT_OFF))
        u5 (.clk(clk), .rstn(rstn), .bus(b5));
    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(FWFT_ON))
        uf (.clk(clk), .rstn(rstn), .bus(bf));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q16[$];
    logic [7:0] q5[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every dout_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (b16.dout_valid === 1'b1) begin
            if (q16.size() == 0) begin
                chk("u16 unexpected dout_valid", 32'(b16.dout), 32'hFFFF_FFFF);
            end else begin
                chk("u16 dout", 32'(b16.dout), 32'(q16.pop_front()));
            end
        end
        if (b5.dout_valid === 1'b1) begin
            if (q5.size() == 0) begin
                chk("u5 unexpected dout_valid", 32'(b5.dout), 32'hFFFF_FFFF);
            end else begin
                chk("u5 dout", 32'(b5.dout), 32'(q5.pop_front()));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        b16.push = 1'b0; b16.pop = 1'b0; b16.din = 8'h00;
        b5.push  = 1'b0; b5.pop  = 1'b0; b5.din  = 8'h00;
        bf.push  = 1'b0; bf.pop  = 1'b0; bf.din  = 8'h00;

        // Reset state
        step(); step();
        chk("rst count", 32'(b16.count), 32'd0);
        chk("rst empty", 32'(b16.empty), 32'd1);
        chk("rst almost_empty", 32'(b16.almost_empty), 32'd1);
        chk("rst full", 32'(b16.full), 32'd0);
        chk("rst almost_full", 32'(b16.almost_full), 32'd0);
        chk("rst dout", 32'(b16.dout), 32'd0);
        chk("rst overflow", 32'(b16.overflow), 32'd0);
        chk("rst underflow", 32'(b16.underflow), 32'd0);
        chk("rst u5 empty", 32'(b5.empty), 32'd1);
        chk("rst uf dout_valid", 32'(bf.dout_valid), 32'd0);
        rstn = 1'b1;
        step();

        // Fill depth-16 FIFO with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            b16.push = 1'b1;
            b16.din  = 8'(i);
            step();
            chk("fill count", 32'(b16.count), 32'(i + 1));
            chk("fill almost_full", 32'(b16.almost_full), 32'((i + 1) >= 12));
            chk("fill almost_empty", 32'(b16.almost_empty), 32'((i + 1) <= 2));
            chk("fill full", 32'(b16.full), 32'((i + 1) == 16));
        end
        b16.din = 8'h11;
        step();
        b16.push = 1'b0;
        chk("17th push overflow", 32'(b16.overflow), 32'd1);
        chk("17th push count", 32'(b16.count), 32'd16);
        step();
        chk("overflow one cycle", 32'(b16.overflow), 32'd0);

        // Full with concurrent push+pop: old head out, 0xAA into freed slot
        b16.push = 1'b1; b16.din = 8'hAA; b16.pop = 1'b1;
        q16.push_back(8'h00);
        step();
        b16.push = 1'b0;
        chk("full push+pop count", 32'(b16.count), 32'd16);
        chk("full push+pop overflow", 32'(b16.overflow), 32'd0);
        chk("full push+pop valid", 32'(b16.dout_valid), 32'd1);

        // Drain: 0x01..0x0F then 0xAA
        for (int i = 1; i <= 16; i++) begin
            q16.push_back((i == 16) ? 8'hAA : 8'(i));
            step();
            chk("drain count", 32'(b16.count), 32'(16 - i));
        end
        b16.pop = 1'b0;
        chk("drain empty", 32'(b16.empty), 32'd1);
        step();
        chk("valid drops after drain", 32'(b16.dout_valid), 32'd0);

        // Pop on empty
        b16.pop = 1'b1;
        step();
        b16.pop = 1'b0;
        chk("empty pop underflow", 32'(b16.underflow), 32'd1);
        chk("empty pop dout held", 32'(b16.dout), 32'h0000_00AA);
        chk("empty pop count", 32'(b16.count), 32'd0);
        step();
        chk("underflow one cycle", 32'(b16.underflow), 32'd0);

        // Push+pop on empty: push taken, pop rejected
        b16.push = 1'b1; b16.din = 8'h33; b16.pop = 1'b1;
        step();
        b16.push = 1'b0; b16.pop = 1'b0;
        chk("empty push+pop count", 32'(b16.count), 32'd1);
        chk("empty push+pop underflow", 32'(b16.underflow), 32'd1);
        chk("empty push+pop empty", 32'(b16.empty), 32'd0);
        b16.pop = 1'b1;
        q16.push_back(8'h33);
        step();
        b16.pop = 1'b0;
        chk("pop 0x33 count", 32'(b16.count), 32'd0);

        // Depth 5: offset pointers by 2, then three rounds straddling the wrap
        b5.push = 1'b1; b5.din = 8'hE0; step();
        b5.din = 8'hE1; step();
        b5.push = 1'b0; b5.pop = 1'b1;
        q5.push_back(8'hE0); step();
        q5.push_back(8'hE1); step();
        b5.pop = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                b5.push = 1'b1;
                b5.din  = 8'(r * 16 + k);
                step();
            end
            b5.push = 1'b0;
            chk("u5 full", 32'(b5.full), 32'd1);
            chk("u5 count 5", 32'(b5.count), 32'd5);
            chk("u5 almost_full", 32'(b5.almost_full), 32'd1);
            for (int k = 0; k < 5; k++) begin
                b5.pop = 1'b1;
                q5.push_back(8'(r * 16 + k));
                step();
            end
            b5.pop = 1'b0;
            chk("u5 count 0", 32'(b5.count), 32'd0);
            chk("u5 empty", 32'(b5.empty), 32'd1);
        end

        // FWFT: write into empty is visible the next cycle
        bf.push = 1'b1; bf.din = 8'h5A;
        step();
        bf.push = 1'b0;
        chk("fwft dout", 32'(bf.dout), 32'h0000_005A);
        chk("fwft valid", 32'(bf.dout_valid), 32'd1);
        chk("fwft not empty", 32'(bf.empty), 32'd0);
        bf.pop = 1'b1;
        step();
        bf.pop = 1'b0;
        chk("fwft pop empty", 32'(bf.empty), 32'd1);
        chk("fwft pop valid", 32'(bf.dout_valid), 32'd0);
        bf.push = 1'b1; bf.din = 8'hA1; step();
        bf.din = 8'hA2; step();
        bf.push = 1'b0;
        chk("fwft head A1", 32'(bf.dout), 32'h0000_00A1);
        bf.pop = 1'b1;
        step();
        bf.pop = 1'b0;
        chk("fwft head A2", 32'(bf.dout), 32'h0000_00A2);
        chk("fwft count 1", 32'(bf.count), 32'd1);

        step(); step();
        chk("u16 scoreboard drained", 32'(q16.size()), 32'd0);
        chk("u5 scoreboard drained", 32'(q5.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
